// File: rtl/risc_io_uart_tx_if.sv
// -----------------------------------------------------------------------------
// risc_io_uart_tx_if
// CPU 8-bit I/O bus as seen by one peripheral.
//   i_bus_address : 8-bit address driven by the CPU
//   i_bus_data    : 8-bit write data driven by the CPU
//   o_bus_data    : 8-bit registered read data returned by the peripheral
//   i_bus_read    : one-cycle read strobe
//   i_bus_write   : one-cycle write strobe
//   o_sel         : combinational address hit, used by the read-data mux
// master = CPU side, slave = peripheral side.
// -----------------------------------------------------------------------------
interface risc_io_uart_tx_if;
  logic [7:0] i_bus_address;
  logic [7:0] i_bus_data;
  logic [7:0] o_bus_data;
  logic       i_bus_read;
  logic       i_bus_write;
  logic       o_sel;

  modport master (
    output i_bus_address,
    output i_bus_data,
    output i_bus_read,
    output i_bus_write,
    input  o_bus_data,
    input  o_sel
  );

  modport slave (
    input  i_bus_address,
    input  i_bus_data,
    input  i_bus_read,
    input  i_bus_write,
    output o_bus_data,
    output o_sel
  );
endinterface

// File: rtl/risc_io_uart_tx.sv
// -----------------------------------------------------------------------------
// risc_io_uart_tx
// Four-register UART transmitter on the CPU I/O bus: 4-entry TX FIFO,
// 16-bit baud divisor (bit period = DIV+1 clocks), 8N1 serial shifter.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   bus    : I/O bus slave port (address, write data, strobes, read data, o_sel)
//   o_tx   : serial output, registered, idles high
// Register map (offset = address[1:0]):
//   0 DATA   W: push byte into FIFO, R: 0x00
//   1 STATUS R: {0, count[2:0], ovf, busy, full, empty}; W: bit3=1 clears ovf
//   2 DIVL   R/W divisor[7:0]
//   3 DIVH   R/W divisor[15:8]
// -----------------------------------------------------------------------------
module risc_io_uart_tx #(
  parameter logic [7:0]  BASE_ADDR   = 8'hF0,
  parameter logic [15:0] DEFAULT_DIV = 16'd103
) (
  input  logic             i_clk,
  input  logic             i_rst,
  risc_io_uart_tx_if.slave bus,
  output logic             o_tx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]  r_fifo_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_ovf;

  // Divisor and frame state
  logic [15:0] r_div;
  logic [15:0] r_frame_div;
  logic [15:0] r_baud_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  state_t      r_state;
  state_t      w_state_next;
  logic        r_tx;
  logic        w_tx_next;

  // Bus side
  logic [7:0]  r_bus_data;
  logic [7:0]  w_rd_data;
  logic [7:0]  w_status;
  logic        w_sel;
  logic        w_wr;
  logic        w_rd;
  logic [1:0]  w_offset;
  logic        w_push;
  logic        w_push_ok;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_bit_end;

  assign w_sel       = (bus.i_bus_address[7:2] == BASE_ADDR[7:2]);
  assign w_offset    = bus.i_bus_address[1:0];
  assign w_wr        = bus.i_bus_write & w_sel;
  assign w_rd        = bus.i_bus_read & w_sel;
  assign w_full      = (r_count == 3'd4);
  assign w_empty     = (r_count == 3'd0);
  assign w_push      = w_wr & (w_offset == 2'd0);
  // Fullness uses the pre-edge count, so a same-cycle pop cannot rescue a push.
  assign w_push_ok   = w_push & ~w_full;
  // Equality compare: the counter never has to pass frame_div, so 0xFFFF is safe.
  assign w_bit_end   = (r_baud_cnt == r_frame_div);
  assign w_status    = {1'b0, r_count, r_ovf, (r_state != ST_IDLE), w_full, w_empty};

  assign bus.o_sel      = w_sel;
  assign bus.o_bus_data = r_bus_data;
  assign o_tx           = r_tx;

  // Read-data mux over the pre-edge register values
  always_comb begin
    w_rd_data = 8'h00;
    case (w_offset)
      2'd0:    w_rd_data = 8'h00;
      2'd1:    w_rd_data = w_status;
      2'd2:    w_rd_data = r_div[7:0];
      2'd3:    w_rd_data = r_div[15:8];
      default: w_rd_data = 8'h00;
    endcase
  end

  // Registered read data, loaded only on a hit read strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bus_data <= 8'h00;
    end else if (w_rd) begin
      r_bus_data <= w_rd_data;
    end else begin
      r_bus_data <= r_bus_data;
    end
  end

  // Divisor and sticky overflow flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= DEFAULT_DIV;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr && (w_offset == 2'd2)) begin
        r_div[7:0] <= bus.i_bus_data;
      end
      if (w_wr && (w_offset == 2'd3)) begin
        r_div[15:8] <= bus.i_bus_data;
      end
      if (w_push && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_offset == 2'd1) && bus.i_bus_data[3]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // TX FIFO: circular buffer with separate occupancy count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        r_fifo_mem[i] <= 8'h00;
      end
    end else begin
      if (w_push_ok) begin
        r_fifo_mem[r_wr_ptr] <= bus.i_bus_data;
        r_wr_ptr             <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM next state and next line level; the line is registered from w_tx_next
  always_comb begin
    w_state_next = r_state;
    w_tx_next    = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
          w_tx_next    = 1'b0;
        end else begin
          w_state_next = ST_IDLE;
          w_tx_next    = 1'b1;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next = ST_DATA;
          w_tx_next    = r_shift[0];
        end else begin
          w_state_next = ST_START;
          w_tx_next    = 1'b0;
        end
      end
      ST_DATA: begin
        // r_shift[0] is always the bit on the line; it shifts at each bit end.
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_next = ST_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_state_next = ST_DATA;
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_state_next = ST_DATA;
          w_tx_next    = r_shift[0];
        end
      end
      ST_STOP: begin
        w_tx_next = 1'b1;
        if (w_bit_end) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_STOP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  // FSM state, line register, shifter and baud counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_tx        <= 1'b1;
      r_shift     <= 8'h00;
      r_frame_div <= 16'h0000;
      r_baud_cnt  <= 16'h0000;
      r_bit_idx   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      if (w_pop) begin
        // Divisor is frozen per frame so mid-frame DIV writes wait for the next one.
        r_shift     <= r_fifo_mem[r_rd_ptr];
        r_frame_div <= r_div;
        r_baud_cnt  <= 16'h0000;
        r_bit_idx   <= 3'd0;
      end else if (r_state != ST_IDLE) begin
        if (w_bit_end) begin
          r_baud_cnt <= 16'h0000;
          if (r_state == ST_DATA) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
          end
        end else begin
          r_baud_cnt <= r_baud_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_risc_io_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_risc_io_uart_tx
// Directed/randomised bench for risc_io_uart_tx. Expected line levels come
// from the 8N1 frame definition (start 0, data LSB first, stop 1, each level
// DIV+1 clocks); expected register values come from the register map.
// -----------------------------------------------------------------------------
module tb_risc_io_uart_tx;

  localparam logic [7:0] A_DATA = 8'hF0;
  localparam logic [7:0] A_STAT = 8'hF1;
  localparam logic [7:0] A_DIVL = 8'hF2;
  localparam logic [7:0] A_DIVH = 8'hF3;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic o_tx;

  int n_vec  = 0;
  int n_miss = 0;

  risc_io_uart_tx_if bus ();

  risc_io_uart_tx #(
    .BASE_ADDR  (8'hF0),
    .DEFAULT_DIV(16'd103)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus),
    .o_tx (o_tx)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle with the given strobes, then strobes drop.
  task automatic bus_cycle(input logic [7:0] addr, input logic [7:0] wdata,
                           input logic rd, input logic wr);
    bus.i_bus_address = addr;
    bus.i_bus_data    = wdata;
    bus.i_bus_read    = rd;
    bus.i_bus_write   = wr;
    tick();
    bus.i_bus_read    = 1'b0;
    bus.i_bus_write   = 1'b0;
  endtask

  // Reference line level for position idx (0..9) of an 8N1 frame.
  function automatic logic frame_level(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx == 9) return 1'b1;
    else return b[idx-1];
  endfunction

  // Check the line for a whole frame from sample 'first' on; optionally
  // poll STATUS every cycle and require busy=1.
  task automatic expect_frame(input logic [7:0] b, input int div, input int first,
                              input logic poll_busy);
    int total;
    total = 10 * (div + 1);
    for (int k = first; k < total; k++) begin
      chk("tx_frame", {15'd0, o_tx}, {15'd0, frame_level(b, k / (div + 1))});
      if (poll_busy) begin
        bus.i_bus_address = A_STAT;
        bus.i_bus_read    = 1'b1;
      end
      tick();
      if (poll_busy) begin
        chk("busy", {15'd0, bus.o_bus_data[2]}, 16'd1);
      end
    end
    bus.i_bus_read = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] q[$];
    logic [7:0] b;
    logic [7:0] b2;
    int         dv;

    bus.i_bus_address = 8'h00;
    bus.i_bus_data    = 8'h00;
    bus.i_bus_read    = 1'b0;
    bus.i_bus_write   = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;

    // Reset state
    chk("rst_tx", {15'd0, o_tx}, 16'd1);
    chk("rst_rdata", {8'd0, bus.o_bus_data}, 16'h0000);
    bus.i_bus_address = A_STAT;
    #1;
    chk("sel_hit", {15'd0, bus.o_sel}, 16'd1);
    bus_cycle(A_STAT, 8'h00, 1'b1, 1'b0);
    chk("rst_status", {8'd0, bus.o_bus_data}, 16'h0001);
    bus_cycle(A_DIVL, 8'h00, 1'b1, 1'b0);
    chk("rst_divl", {8'd0, bus.o_bus_data}, 16'h0067);
    bus_cycle(A_DIVH, 8'h00, 1'b1, 1'b0);
    chk("rst_divh", {8'd0, bus.o_bus_data}, 16'h0000);
    bus_cycle(A_STAT, 8'h00, 1'b1, 1'b0);

    // Non-hit accesses are ignored and leave o_bus_data alone
    bus.i_bus_address = 8'hF4;
    #1;
    chk("sel_miss", {15'd0, bus.o_sel}, 16'd0);
    bus_cycle(8'hF4, 8'h55, 1'b1, 1'b1);
    chk("miss_rdata", {8'd0, bus.o_bus_data}, 16'h0001);
    bus_cycle(8'hF6, 8'h11, 1'b1, 1'b1);
    chk("miss_rdata2", {8'd0, bus.o_bus_data}, 16'h0001);
    chk("miss_tx", {15'd0, o_tx}, 16'd1);
    bus_cycle(A_DIVL, 8'h00, 1'b1, 1'b0);
    chk("miss_divl", {8'd0, bus.o_bus_data}, 16'h0067);
    bus_cycle(A_STAT, 8'h00, 1'b1, 1'b0);
    chk("miss_status", {8'd0, bus.o_bus_data}, 16'h0001);

    // Single frame 0xA5 at DIV=3 with busy polled throughout
    bus_cycle(A_DIVL, 8'h03, 1'b0, 1'b1);
    bus_cycle(A_DIVH, 8'h00, 1'b0, 1'b1);
    bus_cycle(A_DATA, 8'hA5, 1'b0, 1'b1);
    chk("a5_lat", {15'd0, o_tx}, 16'd1);
    tick();
    expect_frame(8'hA5, 3, 0, 1'b1);
    bus_cycle(A_STAT, 8'h00, 1'b1, 1'b0);
    chk("a5_status", {8'd0, bus.o_bus_data}, 16'h0001);

    // Five back-to-back pushes, overflow, ovf clear, frames in order
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      bus_cycle(A_DATA, b, 1'b0, 1'b1);
    end
    bus_cycle(A_STAT, 8'h00, 1'b1, 1'b0);
    chk("full_status", {8'd0, bus.o_bus_data}, 16'h0046);
    bus_cycle(A_DATA, 8'($urandom), 1'b0, 1'b1);
    bus_cycle(A_STAT, 8'h00, 1'b1, 1'b0);
    chk("ovf_status", {8'd0, bus.o_bus_data}, 16'h004E);
    bus_cycle(A_STAT, 8'h08, 1'b0, 1'b1);
    bus_cycle(A_STAT, 8'h00, 1'b1, 1'b0);
    chk("ovf_clear", {8'd0, bus.o_bus_data}, 16'h0046);
    // Frame 1 began 8 cycles ago (first low cycle two after the first push).
    expect_frame(q.pop_front(), 3, 8, 1'b0);
    while (q.size() > 0) begin
      chk("gap_idle", {15'd0, o_tx}, 16'd1);
      tick();
      expect_frame(q.pop_front(), 3, 0, 1'b0);
    end
    chk("post_idle", {15'd0, o_tx}, 16'd1);
    bus_cycle(A_STAT, 8'h00, 1'b1, 1'b0);
    chk("post_status", {8'd0, bus.o_bus_data}, 16'h0001);

    // Mid-frame divisor change applies only to the next frame
    b  = 8'($urandom);
    b2 = 8'($urandom);
    bus_cycle(A_DATA, b, 1'b0, 1'b1);
    bus_cycle(A_DATA, b2, 1'b0, 1'b1);
    chk("mid_start", {15'd0, o_tx}, 16'd0);
    bus_cycle(A_DIVL, 8'h07, 1'b0, 1'b1);
    expect_frame(b, 3, 1, 1'b0);
    chk("mid_gap", {15'd0, o_tx}, 16'd1);
    tick();
    expect_frame(b2, 7, 0, 1'b0);

    // Random bytes at small divisors including DIV=0
    for (int i = 0; i < 4; i++) begin
      dv = (i == 0) ? 0 : int'($urandom_range(0, 2));
      b  = 8'($urandom);
      bus_cycle(A_DIVL, 8'(dv), 1'b0, 1'b1);
      bus_cycle(A_DATA, b, 1'b0, 1'b1);
      chk("rnd_lat", {15'd0, o_tx}, 16'd1);
      tick();
      expect_frame(b, dv, 0, 1'b0);
    end

    // Reset in the middle of DATA discards the frame and the FIFO
    bus_cycle(A_DIVL, 8'h03, 1'b0, 1'b1);
    bus_cycle(A_DATA, 8'h00, 1'b0, 1'b1);
    bus_cycle(A_DATA, 8'h00, 1'b0, 1'b1);
    bus_cycle(A_DATA, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst_tx", {15'd0, o_tx}, 16'd0);
    i_rst = 1'b1;
    tick();
    chk("rst_mid_tx", {15'd0, o_tx}, 16'd1);
    i_rst = 1'b0;
    bus_cycle(A_STAT, 8'h00, 1'b1, 1'b0);
    chk("rst_mid_status", {8'd0, bus.o_bus_data}, 16'h0001);
    bus_cycle(A_DIVL, 8'h00, 1'b1, 1'b0);
    chk("rst_mid_divl", {8'd0, bus.o_bus_data}, 16'h0067);
    bus_cycle(A_DIVH, 8'h00, 1'b1, 1'b0);
    chk("rst_mid_divh", {8'd0, bus.o_bus_data}, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      chk("rst_mid_quiet", {15'd0, o_tx}, 16'd1);
      tick();
    end

    // Simultaneous read and write: read returns the pre-write value
    bus_cycle(A_DIVL, 8'h12, 1'b1, 1'b1);
    chk("rw_old", {8'd0, bus.o_bus_data}, 16'h0067);
    bus_cycle(A_DIVL, 8'h00, 1'b1, 1'b0);
    chk("rw_new", {8'd0, bus.o_bus_data}, 16'h0012);
    bus_cycle(A_DIVH, 8'hFF, 1'b0, 1'b1);
    bus_cycle(A_DIVH, 8'h00, 1'b1, 1'b0);
    chk("divh_ff", {8'd0, bus.o_bus_data}, 16'h00FF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
